// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer: prioritised exception
// types, Cause.ExcCode values, FSM state encoding and CP0 bit positions.
package exc_sequencer_pkg;

  // Prioritised exception types from the MEM-stage prioritiser
  localparam logic [4:0] ExcT_NoExc = 5'd0;
  localparam logic [4:0] ExcT_Intr  = 5'd1;
  localparam logic [4:0] ExcT_TLBM  = 5'd2;
  localparam logic [4:0] ExcT_TLBR  = 5'd3;
  localparam logic [4:0] ExcT_TLBI  = 5'd4;
  localparam logic [4:0] ExcT_AdE   = 5'd5;
  localparam logic [4:0] ExcT_SysC  = 5'd6;
  localparam logic [4:0] ExcT_Bp    = 5'd7;
  localparam logic [4:0] ExcT_RI    = 5'd8;
  localparam logic [4:0] ExcT_CpU   = 5'd9;
  localparam logic [4:0] ExcT_Ov    = 5'd10;
  localparam logic [4:0] ExcT_Trap  = 5'd11;
  localparam logic [4:0] ExcT_IBE   = 5'd12;
  localparam logic [4:0] ExcT_DBE   = 5'd13;
  localparam logic [4:0] ExcT_ERET  = 5'd14;

  // Cause.ExcCode values
  localparam logic [4:0] ExcCode_Int  = 5'd0;
  localparam logic [4:0] ExcCode_Mod  = 5'd1;
  localparam logic [4:0] ExcCode_TLBL = 5'd2;
  localparam logic [4:0] ExcCode_TLBS = 5'd3;
  localparam logic [4:0] ExcCode_AdEL = 5'd4;
  localparam logic [4:0] ExcCode_AdES = 5'd5;
  localparam logic [4:0] ExcCode_IBE  = 5'd6;
  localparam logic [4:0] ExcCode_DBE  = 5'd7;
  localparam logic [4:0] ExcCode_Sys  = 5'd8;
  localparam logic [4:0] ExcCode_Bp   = 5'd9;
  localparam logic [4:0] ExcCode_RI   = 5'd10;
  localparam logic [4:0] ExcCode_CpU  = 5'd11;
  localparam logic [4:0] ExcCode_Ov   = 5'd12;
  localparam logic [4:0] ExcCode_Tr   = 5'd13;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  // Status / Cause bit indices
  localparam int STATUS_BEV = 22;
  localparam int STATUS_ERL = 2;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_IV   = 23;

  // Captured exception held while the data bus drains
  typedef struct packed {
    logic [4:0]  etype;
    logic        save;
    logic [31:0] baddr;
    logic [31:0] pc;
    logic        indelay;
  } exc_req_t;

endpackage

// File: rtl/exc_vector_calc.sv
// Combinational ExcCode mapping and redirect target (vector or ERET return).
module exc_vector_calc
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = 32'hBFC0_0000,
  parameter logic [31:0] KSEG0_BASE = 32'h8000_0000,
  parameter int          EBASE_EN   = 1
) (
  input  logic [4:0]  i_type,
  input  logic        i_save,
  input  logic        i_bev,
  input  logic        i_exl,
  input  logic        i_erl,
  input  logic        i_iv,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_errorepc,
  input  logic [19:0] i_ebase_hi,
  output logic [4:0]  o_code,
  output logic        o_bvaddr_we,
  output logic        o_is_eret,
  output logic [31:0] o_target
);

  logic [31:0] w_base;
  logic [31:0] w_offset;

  assign o_is_eret = (i_type == ExcT_ERET);

  // Map the prioritised type to ExcCode; TLB and address faults split on store
  always_comb begin
    o_code      = ExcCode_Int;
    o_bvaddr_we = 1'b0;
    case (i_type)
      ExcT_Intr: o_code = ExcCode_Int;
      ExcT_TLBM: begin o_code = ExcCode_Mod; o_bvaddr_we = 1'b1; end
      ExcT_TLBR,
      ExcT_TLBI: begin o_code = i_save ? ExcCode_TLBS : ExcCode_TLBL; o_bvaddr_we = 1'b1; end
      ExcT_AdE:  begin o_code = i_save ? ExcCode_AdES : ExcCode_AdEL; o_bvaddr_we = 1'b1; end
      ExcT_SysC: o_code = ExcCode_Sys;
      ExcT_Bp:   o_code = ExcCode_Bp;
      ExcT_RI:   o_code = ExcCode_RI;
      ExcT_CpU:  o_code = ExcCode_CpU;
      ExcT_Ov:   o_code = ExcCode_Ov;
      ExcT_Trap: o_code = ExcCode_Tr;
      ExcT_IBE:  o_code = ExcCode_IBE;
      ExcT_DBE:  o_code = ExcCode_DBE;
      default:   o_code = ExcCode_Int;
    endcase
  end

  // Vector offset: TLB refill gets its own slot only outside EXL
  always_comb begin
    w_offset = 32'h0000_0180;
    if (i_type == ExcT_TLBR && !i_exl)     w_offset = 32'h0000_0000;
    else if (i_type == ExcT_Intr && i_iv)  w_offset = 32'h0000_0200;
  end

  assign w_base   = i_bev ? (RESET_VEC + 32'h0000_0200)
                  : ((EBASE_EN != 0) ? {i_ebase_hi, 12'h000} : KSEG0_BASE);

  assign o_target = o_is_eret ? (i_erl ? i_errorepc : i_epc) : (w_base + w_offset);

endmodule

// File: rtl/exc_sequencer.sv
// Exception/ERET sequencer: capture, drain the data bus, commit CP0 state
// in one cycle, then hand the redirect target to fetch.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = 32'hBFC0_0000,
  parameter logic [31:0] KSEG0_BASE = 32'h8000_0000,
  parameter int          EBASE_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_flag,
  input  logic [4:0]  exc_type,
  input  logic        exc_save,
  input  logic [31:0] exc_baddr,
  input  logic [31:0] exc_pc,
  input  logic        exc_indelay,
  input  logic [31:0] cp0_Status,
  input  logic [31:0] cp0_Cause,
  input  logic [31:0] cp0_EPC,
  input  logic [31:0] cp0_ErrorEPC,
  input  logic [31:0] cp0_EBase,
  input  logic        mem_busy,
  output logic        flush,
  output logic        stall_req,
  output logic        cp0_exc_we,
  output logic        cp0_epc_we,
  output logic [31:0] cp0_exc_epc,
  output logic        cp0_exc_bd,
  output logic [4:0]  cp0_exc_code,
  output logic        cp0_bvaddr_we,
  output logic [31:0] cp0_bvaddr,
  output logic        cp0_eret_we,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  logic [1:0]  r_state;
  exc_req_t    r_req;
  logic [31:0] r_redir_pc;

  logic        w_commit;
  logic [4:0]  w_code;
  logic        w_bvaddr_we;
  logic        w_is_eret;
  logic [31:0] w_target;
  logic        w_unused;

  exc_vector_calc #(
    .RESET_VEC (RESET_VEC),
    .KSEG0_BASE(KSEG0_BASE),
    .EBASE_EN  (EBASE_EN)
  ) u_vec (
    .i_type     (r_req.etype),
    .i_save     (r_req.save),
    .i_bev      (cp0_Status[STATUS_BEV]),
    .i_exl      (cp0_Status[STATUS_EXL]),
    .i_erl      (cp0_Status[STATUS_ERL]),
    .i_iv       (cp0_Cause[CAUSE_IV]),
    .i_epc      (cp0_EPC),
    .i_errorepc (cp0_ErrorEPC),
    .i_ebase_hi (cp0_EBase[31:12]),
    .o_code     (w_code),
    .o_bvaddr_we(w_bvaddr_we),
    .o_is_eret  (w_is_eret),
    .o_target   (w_target)
  );

  // FSM and exception latches; a new flag is only taken in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_redir_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exc_flag && exc_type != ExcT_NoExc) begin
            r_req.etype   <= exc_type;
            r_req.save    <= exc_save;
            r_req.baddr   <= exc_baddr;
            r_req.pc      <= exc_pc;
            r_req.indelay <= exc_indelay;
            r_state       <= ST_DRAIN;
          end
        end
        ST_DRAIN:    if (!mem_busy) r_state <= ST_COMMIT;
        ST_COMMIT: begin
          r_redir_pc <= w_target;
          r_state    <= ST_REDIRECT;
        end
        ST_REDIRECT: if (redir_ready) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_commit      = (r_state == ST_COMMIT);
  assign busy          = (r_state != ST_IDLE);
  assign flush         = busy;
  assign stall_req     = busy;

  // Strobes are decoded from COMMIT so a reset can never leave one behind
  assign cp0_exc_we    = w_commit & ~w_is_eret;
  assign cp0_eret_we   = w_commit &  w_is_eret;
  assign cp0_epc_we    = w_commit & ~w_is_eret & ~cp0_Status[STATUS_EXL];
  assign cp0_bvaddr_we = w_commit & w_bvaddr_we;

  assign cp0_exc_epc   = r_req.indelay ? (r_req.pc - 32'd4) : r_req.pc;
  assign cp0_exc_bd    = r_req.indelay;
  assign cp0_exc_code  = w_code;
  assign cp0_bvaddr    = r_req.baddr;

  assign redir_valid   = (r_state == ST_REDIRECT);
  assign redir_pc      = r_redir_pc;

  // Status/Cause/EBase bits this block does not look at
  assign w_unused = ^{cp0_Status[31:23], cp0_Status[21:3], cp0_Status[0],
                      cp0_Cause[31:24], cp0_Cause[22:0], cp0_EBase[11:0]};

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer; cycle 0 is the cycle exc_flag is presented.
module tb_exc_sequencer;
  import exc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_flag, exc_save, exc_indelay, mem_busy, redir_ready;
  logic [4:0]  exc_type;
  logic [31:0] exc_baddr, exc_pc;
  logic [31:0] cp0_Status, cp0_Cause, cp0_EPC, cp0_ErrorEPC, cp0_EBase;
  logic        flush, stall_req, cp0_exc_we, cp0_epc_we, cp0_exc_bd;
  logic        cp0_bvaddr_we, cp0_eret_we, redir_valid, busy;
  logic [31:0] cp0_exc_epc, cp0_bvaddr, redir_pc;
  logic [4:0]  cp0_exc_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_sequencer dut (
    .clk(clk), .rst(rst),
    .exc_flag(exc_flag), .exc_type(exc_type), .exc_save(exc_save),
    .exc_baddr(exc_baddr), .exc_pc(exc_pc), .exc_indelay(exc_indelay),
    .cp0_Status(cp0_Status), .cp0_Cause(cp0_Cause), .cp0_EPC(cp0_EPC),
    .cp0_ErrorEPC(cp0_ErrorEPC), .cp0_EBase(cp0_EBase),
    .mem_busy(mem_busy),
    .flush(flush), .stall_req(stall_req),
    .cp0_exc_we(cp0_exc_we), .cp0_epc_we(cp0_epc_we),
    .cp0_exc_epc(cp0_exc_epc), .cp0_exc_bd(cp0_exc_bd),
    .cp0_exc_code(cp0_exc_code),
    .cp0_bvaddr_we(cp0_bvaddr_we), .cp0_bvaddr(cp0_bvaddr),
    .cp0_eret_we(cp0_eret_we),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
    .busy(busy)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_exc(input logic [4:0] t, input logic s, input logic [31:0] ba,
                         input logic [31:0] pc, input logic ind);
    exc_type = t; exc_save = s; exc_baddr = ba; exc_pc = pc; exc_indelay = ind;
    exc_flag = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; exc_flag = 0; exc_type = 0; exc_save = 0; exc_baddr = 0; exc_pc = 0;
    exc_indelay = 0; cp0_Status = 0; cp0_Cause = 0; cp0_EPC = 0; cp0_ErrorEPC = 0;
    cp0_EBase = 0; mem_busy = 0; redir_ready = 0;
    #12;
    checks++;
    if ({flush, stall_req, busy, redir_valid, cp0_exc_we, cp0_epc_we, cp0_bvaddr_we,
         cp0_eret_we, cp0_exc_bd} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {flush, stall_req, busy, redir_valid,
        cp0_exc_we, cp0_epc_we, cp0_bvaddr_we, cp0_eret_we, cp0_exc_bd});
    end
    checks++;
    if ({redir_pc, cp0_exc_epc, cp0_bvaddr, cp0_exc_code} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", redir_pc, cp0_exc_epc,
        cp0_bvaddr, cp0_exc_code);
    end
    cyc(); rst = 1'b0;
  endtask

  // Syscall, plus a flag raised on the REDIRECT->IDLE edge that must be dropped
  task automatic test_sys();
    cyc();
    cp0_Status = 0; cp0_Cause = 0; cp0_EBase = 32'h8000_0000; mem_busy = 0; redir_ready = 1;
    set_exc(ExcT_SysC, 0, 0, 32'h8000_1000, 0);
    cyc(); exc_flag = 0;                                   // cycle 1
    checks++;
    if ({flush, stall_req, busy, cp0_exc_we} !== 4'b1110) begin
      errors++; $display("FAIL sys_c1 got %b exp 1110", {flush, stall_req, busy, cp0_exc_we});
    end
    cyc();                                                 // cycle 2
    checks++;
    if ({cp0_exc_we, cp0_epc_we, cp0_eret_we, cp0_bvaddr_we, cp0_exc_bd} !== 5'b11000) begin
      errors++; $display("FAIL sys_strobes got %b exp 11000",
        {cp0_exc_we, cp0_epc_we, cp0_eret_we, cp0_bvaddr_we, cp0_exc_bd});
    end
    checks++;
    if (cp0_exc_code !== 5'd8 || cp0_exc_epc !== 32'h8000_1000) begin
      errors++; $display("FAIL sys_code_epc got %0d %h exp 8 80001000", cp0_exc_code, cp0_exc_epc);
    end
    cyc();                                                 // cycle 3
    checks++;
    if ({redir_valid, cp0_exc_we} !== 2'b10 || redir_pc !== 32'h8000_0180) begin
      errors++; $display("FAIL sys_redir got %b %h exp 10 80000180", {redir_valid, cp0_exc_we}, redir_pc);
    end
    set_exc(ExcT_Ov, 0, 0, 32'h8000_2000, 0);              // coincides with return to IDLE
    cyc(); exc_flag = 0;                                   // cycle 4
    checks++;
    if ({flush, busy, redir_valid} !== 3'b000) begin
      errors++; $display("FAIL sys_idle_c4 got %b exp 000", {flush, busy, redir_valid});
    end
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drop_at_return got %b exp 0", busy);
    end
  endtask

  task automatic test_tlbr_delay();
    cyc();
    cp0_Status = 0; cp0_EBase = 32'h8000_0000; mem_busy = 0; redir_ready = 1;
    set_exc(ExcT_TLBR, 1, 32'h1234_5678, 32'h0040_0004, 1);
    cyc(); exc_flag = 0;
    cyc();                                                 // cycle 2
    checks++;
    if (cp0_exc_code !== 5'd3 || cp0_exc_bd !== 1'b1 || cp0_exc_epc !== 32'h0040_0000) begin
      errors++; $display("FAIL tlbr_cause got %0d %b %h exp 3 1 00400000", cp0_exc_code,
        cp0_exc_bd, cp0_exc_epc);
    end
    checks++;
    if (cp0_bvaddr_we !== 1'b1 || cp0_bvaddr !== 32'h1234_5678 || cp0_exc_we !== 1'b1) begin
      errors++; $display("FAIL tlbr_bvaddr got %b %h %b exp 1 12345678 1", cp0_bvaddr_we,
        cp0_bvaddr, cp0_exc_we);
    end
    cyc();
    checks++;
    if (redir_pc !== 32'h8000_0000) begin
      errors++; $display("FAIL tlbr_vec got %h exp 80000000", redir_pc);
    end
    cyc();
  endtask

  task automatic test_intr(input logic exl);
    cyc();
    cp0_Status = 32'h0040_0000 | {30'd0, exl, 1'b0}; cp0_Cause = 32'h0080_0000;
    mem_busy = 0; redir_ready = 1;
    set_exc(ExcT_Intr, 0, 0, 32'h8000_3000, 0);
    cyc(); exc_flag = 0;
    cyc();
    checks++;
    if (cp0_exc_we !== 1'b1 || cp0_epc_we !== ~exl || cp0_exc_code !== 5'd0 ||
        cp0_bvaddr_we !== 1'b0) begin
      errors++; $display("FAIL intr_exl%0b got we=%b epc_we=%b code=%0d bv=%b exp 1 %b 0 0", exl,
        cp0_exc_we, cp0_epc_we, cp0_exc_code, cp0_bvaddr_we, ~exl);
    end
    cyc();
    checks++;
    if (redir_pc !== 32'hBFC0_0400) begin
      errors++; $display("FAIL intr_vec_exl%0b got %h exp bfc00400", exl, redir_pc);
    end
    cyc();
    cp0_Status = 0; cp0_Cause = 0;
  endtask

  task automatic test_eret();
    int exc_seen = 0;
    cyc();
    cp0_Status = 32'h0000_0004; cp0_EPC = 32'h8000_2000; cp0_ErrorEPC = 32'hBFC0_0010;
    mem_busy = 0; redir_ready = 1;
    set_exc(ExcT_ERET, 0, 0, 32'h8000_4000, 0);
    cyc(); exc_flag = 0; exc_seen += cp0_exc_we;
    cyc(); exc_seen += cp0_exc_we;                         // cycle 2
    checks++;
    if (cp0_eret_we !== 1'b1 || cp0_epc_we !== 1'b0) begin
      errors++; $display("FAIL eret_strobe got %b %b exp 1 0", cp0_eret_we, cp0_epc_we);
    end
    cyc(); exc_seen += cp0_exc_we;
    checks++;
    if (redir_pc !== 32'hBFC0_0010 || cp0_eret_we !== 1'b0) begin
      errors++; $display("FAIL eret_target got %h %b exp bfc00010 0", redir_pc, cp0_eret_we);
    end
    cyc(); exc_seen += cp0_exc_we;
    checks++;
    if (exc_seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL eret_no_exc_we got %0d %b exp 0 0", exc_seen, busy);
    end
    cp0_Status = 0;
  endtask

  // Busy drain (cycles 0-2), second flag during DRAIN, fetch stalls 2 cycles
  task automatic test_back_to_back();
    logic [31:0] held;
    cyc();
    cp0_EBase = 32'h8000_0000; mem_busy = 1; redir_ready = 0;
    set_exc(ExcT_Ov, 0, 0, 32'h8000_5000, 0);
    cyc(); exc_flag = 0;                                   // cycle 1
    cyc(); set_exc(ExcT_SysC, 0, 0, 32'h8000_6000, 0);     // cycle 2
    checks++;
    if ({busy, cp0_exc_we} !== 2'b10) begin
      errors++; $display("FAIL drain_c2 got %b exp 10", {busy, cp0_exc_we});
    end
    cyc(); exc_flag = 0; mem_busy = 0;                     // cycle 3
    checks++;
    if (cp0_exc_we !== 1'b0) begin
      errors++; $display("FAIL drain_c3_early got %b exp 0", cp0_exc_we);
    end
    cyc();                                                 // cycle 4
    checks++;
    if (cp0_exc_we !== 1'b1 || cp0_exc_code !== 5'd12 || cp0_exc_epc !== 32'h8000_5000) begin
      errors++; $display("FAIL drain_commit got %b %0d %h exp 1 12 80005000", cp0_exc_we,
        cp0_exc_code, cp0_exc_epc);
    end
    cyc(); held = redir_pc;                                // cycle 5
    checks++;
    if (held !== 32'h8000_0180 || redir_valid !== 1'b1) begin
      errors++; $display("FAIL redir_c5 got %h %b exp 80000180 1", held, redir_valid);
    end
    cyc();                                                 // cycle 6
    checks++;
    if (redir_pc !== 32'h8000_0180 || redir_valid !== 1'b1) begin
      errors++; $display("FAIL redir_hold_c6 got %h %b exp 80000180 1", redir_pc, redir_valid);
    end
    redir_ready = 1;
    cyc();                                                 // cycle 7
    checks++;
    if ({busy, redir_valid} !== 2'b00) begin
      errors++; $display("FAIL redir_release got %b exp 00", {busy, redir_valid});
    end
  endtask

  task automatic test_reset_in_drain();
    int strobes = 0;
    cyc();
    mem_busy = 1; redir_ready = 1;
    set_exc(ExcT_AdE, 0, 32'h0000_0003, 32'h8000_7000, 1);
    cyc(); exc_flag = 0;
    cyc();
    rst = 1'b1; #1;
    checks++;
    if ({flush, stall_req, busy, cp0_exc_we, cp0_eret_we, cp0_bvaddr_we} !== 6'b0 ||
        redir_pc !== 32'h0 || cp0_exc_epc !== 32'h0) begin
      errors++; $display("FAIL rst_drain got %b %h %h exp 0", {flush, stall_req, busy,
        cp0_exc_we, cp0_eret_we, cp0_bvaddr_we}, redir_pc, cp0_exc_epc);
    end
    cyc(); rst = 1'b0; mem_busy = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); strobes += cp0_exc_we + cp0_eret_we + cp0_epc_we + cp0_bvaddr_we + busy;
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL rst_no_strobe got %0d exp 0", strobes);
    end
  endtask

  task automatic test_noexc_ignored();
    cyc(); set_exc(ExcT_NoExc, 0, 0, 32'h8000_8000, 0);
    cyc(); exc_flag = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL noexc_ignored got %b exp 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_sys();
    test_tlbr_delay();
    test_intr(1'b0);
    test_intr(1'b1);
    test_eret();
    test_back_to_back();
    test_reset_in_drain();
    test_noexc_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
